// File: rtl/axi_hier_rd_node_pkg.sv
// Shared types and widths for the hierarchical AXI read node and its arbiter.
package axi_hier_rd_node_pkg;

  typedef enum logic {
    ArbRR  = 1'b0,
    ArbQoS = 1'b1
  } rd_arb_mode_e;

  localparam int unsigned LenWidth  = 8;
  localparam int unsigned QosWidth  = 4;
  localparam int unsigned RespWidth = 2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

endpackage

// File: rtl/axi_hier_rd_node_if.sv
// AR/R channel bundle for NumPorts ports; master drives AR and R ready, slave drives AR ready and R.
interface axi_hier_rd_node_if
  import axi_hier_rd_node_pkg::*;
#(
  parameter int unsigned NumPorts  = 1,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
);
  logic [NumPorts-1:0]                 ar_valid;
  logic [NumPorts-1:0]                 ar_ready;
  logic [NumPorts-1:0][IdWidth-1:0]    ar_id;
  logic [NumPorts-1:0][AddrWidth-1:0]  ar_addr;
  logic [NumPorts-1:0][LenWidth-1:0]   ar_len;
  logic [NumPorts-1:0][QosWidth-1:0]   ar_qos;
  logic [NumPorts-1:0]                 r_valid;
  logic [NumPorts-1:0]                 r_ready;
  logic [NumPorts-1:0][IdWidth-1:0]    r_id;
  logic [NumPorts-1:0][DataWidth-1:0]  r_data;
  logic [NumPorts-1:0][RespWidth-1:0]  r_resp;
  logic [NumPorts-1:0]                 r_last;

  modport master (
    output ar_valid, ar_id, ar_addr, ar_len, ar_qos, r_ready,
    input  ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );

  modport slave (
    input  ar_valid, ar_id, ar_addr, ar_len, ar_qos, r_ready,
    output ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );
endinterface

// File: rtl/axi_hier_rd_node_qos_arb.sv
// Combinational N-way arbiter: optional max-QoS filter, then first candidate at or after ptr.
// Zero latency; no state, the caller owns the pointer and decides when a grant is taken.
module axi_hier_rd_node_qos_arb
  import axi_hier_rd_node_pkg::*;
#(
  parameter int unsigned  NumPorts = 4,
  parameter int unsigned  PtrWidth = 2,
  parameter rd_arb_mode_e Mode     = ArbRR
) (
  input  logic [NumPorts-1:0]               elig,
  input  logic [NumPorts-1:0][QosWidth-1:0] qos,
  input  logic [PtrWidth-1:0]               ptr,
  output logic                              gnt_vld,
  output logic [NumPorts-1:0]               gnt_oh,
  output logic [PtrWidth-1:0]               gnt_idx
);
  logic [QosWidth-1:0] max_qos;
  logic [NumPorts-1:0] cand;

  always_comb begin
    max_qos = '0;
    cand    = '0;
    for (int i = 0; i < NumPorts; i++)
      if (elig[i] && qos[i] > max_qos) max_qos = qos[i];
    for (int i = 0; i < NumPorts; i++)
      cand[i] = elig[i] && (Mode == ArbRR || qos[i] == max_qos);
  end

  always_comb begin
    int unsigned j;
    logic [PtrWidth-1:0] jj;
    j       = 0;
    jj      = '0;
    gnt_vld = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      j  = (32'(ptr) + k) % NumPorts;
      jj = PtrWidth'(j);
      if (!gnt_vld && cand[jj]) begin
        gnt_vld    = 1'b1;
        gnt_idx    = jj;
        gnt_oh[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_hier_rd_node.sv
// N:1 AXI read node: AR arbitrated into a one-entry register (1 cycle, 1 AR/cycle), port index prepended to ID.
// R routed back combinationally by index; a port at its outstanding limit or a full stalled AR register gets no ready.
module axi_hier_rd_node
  import axi_hier_rd_node_pkg::*;
#(
  parameter int unsigned NumSlvPorts   = 4,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned SlvIdWidth    = 3,
  parameter int unsigned MaxTxnPerPort = 8,
  parameter int unsigned ArbMode       = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  axi_hier_rd_node_if.slave  slv,
  axi_hier_rd_node_if.master mst,
  output logic               busy_o,
  output logic               err_o
);
  localparam int unsigned  IdxWidth   = idx_width(NumSlvPorts);
  localparam int unsigned  MstIdWidth = SlvIdWidth + IdxWidth;
  localparam int unsigned  PtrWidth   = (IdxWidth > 0) ? IdxWidth : 1;
  localparam int unsigned  CntWidth   = $clog2(MaxTxnPerPort + 1);
  localparam rd_arb_mode_e Mode       = (ArbMode == 1) ? ArbQoS : ArbRR;

  logic [NumSlvPorts-1:0][CntWidth-1:0] cnt_q;
  logic [NumSlvPorts-1:0] elig, gnt_oh, inc, dec;
  logic                   gnt_vld, ar_load, ar_hs, r_hs, r_in_range;
  logic                   ar_q_valid, err_q;
  logic [PtrWidth-1:0]    gnt_idx, ptr_q, r_port;
  logic [MstIdWidth-1:0]  ar_id_d, ar_id_q;
  logic [AddrWidth-1:0]   ar_addr_q;
  logic [LenWidth-1:0]    ar_len_q;
  logic [QosWidth-1:0]    ar_qos_q;
  logic [DataWidth-1:0]   r_data;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NumSlvPorts; i++)
      elig[i] = slv.ar_valid[i] && (cnt_q[i] < CntWidth'(MaxTxnPerPort));
  end

  axi_hier_rd_node_qos_arb #(
    .NumPorts (NumSlvPorts),
    .PtrWidth (PtrWidth),
    .Mode     (Mode)
  ) u_arb (
    .elig    (elig),
    .qos     (slv.ar_qos),
    .ptr     (ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  assign ar_load      = !ar_q_valid || mst.ar_ready[0];
  assign ar_hs        = gnt_vld && ar_load && !rst_i;
  assign slv.ar_ready = ar_hs ? gnt_oh : '0;

  // Index bits exist only with more than one port; a single port passes its ID through.
  if (IdxWidth > 0) begin : g_idx
    assign ar_id_d    = {gnt_idx, slv.ar_id[gnt_idx]};
    assign r_port     = mst.r_id[0][MstIdWidth-1 -: PtrWidth];
    assign r_in_range = (32'(r_port) < NumSlvPorts);
  end else begin : g_no_idx
    assign ar_id_d    = slv.ar_id[0];
    assign r_port     = '0;
    assign r_in_range = 1'b1;
  end

  assign r_data = mst.r_data[0];

  always_comb begin
    mst.r_ready = 1'b0;
    slv.r_valid = '0;
    for (int i = 0; i < NumSlvPorts; i++) begin
      slv.r_id[i]   = mst.r_id[0][SlvIdWidth-1:0];
      slv.r_data[i] = r_data;
      slv.r_resp[i] = mst.r_resp[0];
      slv.r_last[i] = mst.r_last[0];
    end
    if (!rst_i) begin
      if (r_in_range) begin
        mst.r_ready         = slv.r_ready[r_port];
        slv.r_valid[r_port] = mst.r_valid[0];
      end else begin
        mst.r_ready = 1'b1;
      end
    end
  end

  assign r_hs = mst.r_valid[0] && mst.r_ready[0];

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NumSlvPorts; i++) begin
      inc[i] = ar_hs && (gnt_idx == PtrWidth'(i));
      dec[i] = r_hs && r_in_range && mst.r_last[0] && (r_port == PtrWidth'(i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NumSlvPorts; i++)
        if (inc[i] && !dec[i])      cnt_q[i] <= cnt_q[i] + CntWidth'(1);
        else if (dec[i] && !inc[i]) cnt_q[i] <= cnt_q[i] - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      err_q      <= 1'b0;
      ar_q_valid <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_qos_q   <= '0;
    end else begin
      if (ar_hs) ptr_q <= (32'(gnt_idx) == NumSlvPorts - 1) ? '0 : gnt_idx + PtrWidth'(1);
      if (mst.r_valid[0] && !r_in_range) err_q <= 1'b1;
      if (ar_load) begin
        ar_q_valid <= gnt_vld;
        if (gnt_vld) begin
          ar_id_q   <= ar_id_d;
          ar_addr_q <= slv.ar_addr[gnt_idx];
          ar_len_q  <= slv.ar_len[gnt_idx];
          ar_qos_q  <= slv.ar_qos[gnt_idx];
        end
      end
    end
  end

  assign mst.ar_valid = ar_q_valid;
  assign mst.ar_id    = ar_id_q;
  assign mst.ar_addr  = ar_addr_q;
  assign mst.ar_len   = ar_len_q;
  assign mst.ar_qos   = ar_qos_q;
  assign busy_o       = ar_q_valid || (|cnt_q);
  assign err_o        = err_q;

  // A last beat for a port with nothing outstanding means the downstream slave misbehaved.
  for (genvar i = 0; i < NumSlvPorts; i++) begin : g_cnt_chk
    assert property (@(posedge clk_i) disable iff (rst_i) !(dec[i] && cnt_q[i] == '0));
  end

endmodule

// File: tb/tb_axi_hier_rd_node.sv
// Directed bench for axi_hier_rd_node: RR (N=4, limit 2), QoS (N=4), and N=3 error routing instances.
module tb_axi_hier_rd_node;
  import axi_hier_rd_node_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic busy_a, err_a, busy_b, err_b, busy_c, err_c;

  always #5 clk = ~clk;

  axi_hier_rd_node_if #(.NumPorts(4), .IdWidth(3)) a_s ();
  axi_hier_rd_node_if #(.NumPorts(1), .IdWidth(5)) a_m ();
  axi_hier_rd_node_if #(.NumPorts(4), .IdWidth(3)) b_s ();
  axi_hier_rd_node_if #(.NumPorts(1), .IdWidth(5)) b_m ();
  axi_hier_rd_node_if #(.NumPorts(3), .IdWidth(3)) c_s ();
  axi_hier_rd_node_if #(.NumPorts(1), .IdWidth(5)) c_m ();

  axi_hier_rd_node #(.NumSlvPorts(4), .AddrWidth(32), .DataWidth(64), .SlvIdWidth(3),
                     .MaxTxnPerPort(2), .ArbMode(0)) u_a (
    .clk_i(clk), .rst_i(rst), .slv(a_s), .mst(a_m), .busy_o(busy_a), .err_o(err_a));
  axi_hier_rd_node #(.NumSlvPorts(4), .AddrWidth(32), .DataWidth(64), .SlvIdWidth(3),
                     .MaxTxnPerPort(8), .ArbMode(1)) u_b (
    .clk_i(clk), .rst_i(rst), .slv(b_s), .mst(b_m), .busy_o(busy_b), .err_o(err_b));
  axi_hier_rd_node #(.NumSlvPorts(3), .AddrWidth(32), .DataWidth(64), .SlvIdWidth(3),
                     .MaxTxnPerPort(8), .ArbMode(0)) u_c (
    .clk_i(clk), .rst_i(rst), .slv(c_s), .mst(c_m), .busy_o(busy_c), .err_o(err_c));

  task automatic clear_inputs();
    a_s.ar_valid = '0; a_s.ar_id = '0; a_s.ar_addr = '0; a_s.ar_len = '0; a_s.ar_qos = '0; a_s.r_ready = '0;
    b_s.ar_valid = '0; b_s.ar_id = '0; b_s.ar_addr = '0; b_s.ar_len = '0; b_s.ar_qos = '0; b_s.r_ready = '0;
    c_s.ar_valid = '0; c_s.ar_id = '0; c_s.ar_addr = '0; c_s.ar_len = '0; c_s.ar_qos = '0; c_s.r_ready = '0;
    a_m.ar_ready = '0; a_m.r_valid = '0; a_m.r_id = '0; a_m.r_data = '0; a_m.r_resp = '0; a_m.r_last = '0;
    b_m.ar_ready = '0; b_m.r_valid = '0; b_m.r_id = '0; b_m.r_data = '0; b_m.r_resp = '0; b_m.r_last = '0;
    c_m.ar_ready = '0; c_m.r_valid = '0; c_m.r_id = '0; c_m.r_data = '0; c_m.r_resp = '0; c_m.r_last = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_s.ar_valid = 4'hF; a_s.r_ready = 4'hF; a_m.ar_ready = 1'b1;
    a_m.r_valid = 1'b1; a_m.r_id = 5'b01_000; a_m.r_last = 1'b1;
    c_m.r_valid = 1'b1; c_m.r_id = 5'b11_000;
    step();
    n_cmp++; if (a_s.ar_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ar_ready: got %b want 0000", a_s.ar_ready); end
    n_cmp++; if (a_m.ar_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mst_ar_valid: got %b want 0", a_m.ar_valid); end
    n_cmp++; if (a_m.r_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mst_r_ready: got %b want 0", a_m.r_ready); end
    n_cmp++; if (a_s.r_valid !== 4'b0000) begin n_bad++; $display("FAIL rst_slv_r_valid: got %b want 0000", a_s.r_valid); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    n_cmp++; if (err_c !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_c); end
    clear_inputs();
    rst = 1'b0;
    step();
    n_cmp++; if (busy_a !== 1'b0 || a_m.ar_valid !== 1'b0) begin n_bad++; $display("FAIL rst_idle: got busy=%b valid=%b want 0/0", busy_a, a_m.ar_valid); end
  endtask

  task automatic test_rr();
    logic [1:0] g;
    logic [3:0] exp_oh;
    for (int i = 0; i < 4; i++) begin
      a_s.ar_id[i] = 3'd5; a_s.ar_addr[i] = 32'h100 * (i + 1); a_s.ar_len[i] = 8'(i);
    end
    a_s.ar_valid = 4'hF;
    a_m.ar_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      g      = 2'(c % 4);
      exp_oh = 4'b0001 << g;
      #1;
      n_cmp++; if (a_s.ar_ready !== exp_oh) begin n_bad++; $display("FAIL rr_grant c=%0d: got %b want %b", c, a_s.ar_ready, exp_oh); end
      step();
      n_cmp++; if (a_m.ar_valid !== 1'b1 || a_m.ar_id !== {g, 3'd5}) begin n_bad++; $display("FAIL rr_id c=%0d: got v=%b id=%b want 1/%b", c, a_m.ar_valid, a_m.ar_id, {g, 3'd5}); end
      n_cmp++; if (a_m.ar_addr !== 32'h100 * (g + 1) || a_m.ar_len !== 8'(g)) begin n_bad++; $display("FAIL rr_addr c=%0d: got %h/%0d", c, a_m.ar_addr, a_m.ar_len); end
    end
    #1;
    n_cmp++; if (a_s.ar_ready !== 4'b0000 || busy_a !== 1'b1) begin n_bad++; $display("FAIL rr_full: got ready=%b busy=%b want 0000/1", a_s.ar_ready, busy_a); end
    step();
    n_cmp++; if (a_m.ar_valid !== 1'b0) begin n_bad++; $display("FAIL rr_drain: got %b want 0", a_m.ar_valid); end
    do_reset();
  endtask

  task automatic test_limit();
    a_s.ar_valid = 4'b0001; a_s.ar_id[0] = 3'd1; a_m.ar_ready = 1'b1;
    #1;
    n_cmp++; if (a_s.ar_ready !== 4'b0001) begin n_bad++; $display("FAIL lim_first: got %b want 0001", a_s.ar_ready); end
    step(); #1;
    n_cmp++; if (a_s.ar_ready !== 4'b0001) begin n_bad++; $display("FAIL lim_second: got %b want 0001", a_s.ar_ready); end
    step(); #1;
    n_cmp++; if (a_s.ar_ready !== 4'b0000 || busy_a !== 1'b1) begin n_bad++; $display("FAIL lim_held: got ready=%b busy=%b want 0000/1", a_s.ar_ready, busy_a); end
    step();
    a_m.r_valid = 1'b1; a_m.r_id = 5'b00_001; a_m.r_last = 1'b1; a_m.r_data = 64'hDEAD_BEEF_0000_0001;
    a_s.r_ready = 4'b0001;
    #1;
    n_cmp++; if (a_s.r_valid !== 4'b0001 || a_m.r_ready !== 1'b1) begin n_bad++; $display("FAIL lim_r_route: got valid=%b ready=%b want 0001/1", a_s.r_valid, a_m.r_ready); end
    n_cmp++; if (a_s.r_id[0] !== 3'd1 || a_s.r_data[0] !== 64'hDEAD_BEEF_0000_0001) begin n_bad++; $display("FAIL lim_r_data: got id=%0d data=%h", a_s.r_id[0], a_s.r_data[0]); end
    n_cmp++; if (a_s.ar_ready !== 4'b0000) begin n_bad++; $display("FAIL lim_r_cycle_ready: got %b want 0000", a_s.ar_ready); end
    step();
    a_m.r_valid = 1'b0; a_s.r_ready = 4'b0000;
    #1;
    n_cmp++; if (a_s.ar_ready !== 4'b0001) begin n_bad++; $display("FAIL lim_release: got %b want 0001", a_s.ar_ready); end
    step();
    n_cmp++; if (a_m.ar_valid !== 1'b1 || a_m.ar_id !== 5'b00_001) begin n_bad++; $display("FAIL lim_third_ar: got v=%b id=%b want 1/00001", a_m.ar_valid, a_m.ar_id); end
    do_reset();
  endtask

  task automatic test_stall();
    a_s.ar_id[1] = 3'd2; a_s.ar_id[2] = 3'd3; a_s.ar_id[3] = 3'd4;
    a_s.ar_addr[1] = 32'hA1; a_s.ar_addr[2] = 32'hA2; a_s.ar_addr[3] = 32'hA3;
    a_s.ar_valid = 4'b0110;
    a_m.ar_ready = 1'b0;
    #1;
    n_cmp++; if (a_s.ar_ready !== 4'b0010) begin n_bad++; $display("FAIL stall_first: got %b want 0010", a_s.ar_ready); end
    step();
    a_s.ar_valid = 4'b1100;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (a_s.ar_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready k=%0d: got %b want 0000", k, a_s.ar_ready); end
      n_cmp++; if (a_m.ar_valid !== 1'b1 || a_m.ar_id !== 5'b01_010 || a_m.ar_addr !== 32'hA1) begin n_bad++; $display("FAIL stall_hold k=%0d: got v=%b id=%b addr=%h", k, a_m.ar_valid, a_m.ar_id, a_m.ar_addr); end
      step();
    end
    a_m.ar_ready = 1'b1;
    #1;
    n_cmp++; if (a_s.ar_ready !== 4'b0100) begin n_bad++; $display("FAIL stall_resume: got %b want 0100", a_s.ar_ready); end
    step();
    a_s.ar_valid = 4'b1000;
    #1;
    n_cmp++; if (a_m.ar_id !== 5'b10_011 || a_s.ar_ready !== 4'b1000) begin n_bad++; $display("FAIL stall_drain1: got id=%b ready=%b want 10011/1000", a_m.ar_id, a_s.ar_ready); end
    step();
    a_s.ar_valid = 4'b0000;
    #1;
    n_cmp++; if (a_m.ar_valid !== 1'b1 || a_m.ar_id !== 5'b11_100) begin n_bad++; $display("FAIL stall_drain2: got v=%b id=%b want 1/11100", a_m.ar_valid, a_m.ar_id); end
    step();
    n_cmp++; if (a_m.ar_valid !== 1'b0) begin n_bad++; $display("FAIL stall_empty: got %b want 0", a_m.ar_valid); end
  endtask

  // Continues from test_stall: ports 1..3 each hold one outstanding read.
  task automatic test_same_cycle();
    a_s.ar_valid = 4'b0100; a_s.ar_id[2] = 3'd6;
    a_m.r_valid = 1'b1; a_m.r_id = 5'b10_011; a_m.r_last = 1'b1; a_s.r_ready = 4'b0100;
    #1;
    n_cmp++; if (a_s.ar_ready !== 4'b0100 || a_s.r_valid !== 4'b0100 || a_m.r_ready !== 1'b1) begin n_bad++; $display("FAIL same_both: got ar=%b r=%b rr=%b", a_s.ar_ready, a_s.r_valid, a_m.r_ready); end
    step();
    a_m.r_valid = 1'b0; a_s.r_ready = 4'b0000;
    #1;
    n_cmp++; if (a_s.ar_ready !== 4'b0100) begin n_bad++; $display("FAIL same_cnt_kept: got %b want 0100", a_s.ar_ready); end
    step(); #1;
    n_cmp++; if (a_s.ar_ready !== 4'b0000 || busy_a !== 1'b1) begin n_bad++; $display("FAIL same_cnt_full: got ready=%b busy=%b want 0000/1", a_s.ar_ready, busy_a); end
  endtask

  task automatic test_reset_mid();
    a_m.r_valid = 1'b1; a_m.r_id = 5'b01_010; a_m.r_last = 1'b0; a_s.r_ready = 4'b0010;
    rst = 1'b1;
    #1;
    n_cmp++; if (busy_a !== 1'b0 || a_m.ar_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got busy=%b v=%b want 0/0", busy_a, a_m.ar_valid); end
    n_cmp++; if (a_s.r_valid !== 4'b0000 || a_s.ar_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_outs: got r=%b ar=%b want 0", a_s.r_valid, a_s.ar_ready); end
    clear_inputs();
    step();
    rst = 1'b0;
    a_s.ar_valid = 4'b0100; a_m.ar_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (a_s.ar_ready[2] !== (k < 2)) begin n_bad++; $display("FAIL mid_cnt_zero k=%0d: got %b want %b", k, a_s.ar_ready[2], (k < 2)); end
      step();
    end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL a_err: got %b want 0", err_a); end
    do_reset();
  endtask

  task automatic test_qos();
    b_s.ar_qos[1] = 4'd5; b_s.ar_qos[3] = 4'd9; b_s.ar_id[1] = 3'd1; b_s.ar_id[3] = 3'd3;
    b_s.ar_valid = 4'b1010; b_m.ar_ready = 1'b1;
    #1;
    n_cmp++; if (b_s.ar_ready !== 4'b1000) begin n_bad++; $display("FAIL qos_high: got %b want 1000", b_s.ar_ready); end
    step();
    b_s.ar_valid = 4'b0010;
    #1;
    n_cmp++; if (b_s.ar_ready !== 4'b0010 || b_m.ar_id !== 5'b11_011) begin n_bad++; $display("FAIL qos_next: got ready=%b id=%b want 0010/11011", b_s.ar_ready, b_m.ar_id); end
    step();
    b_s.ar_valid = 4'b0000;
    #1;
    n_cmp++; if (b_m.ar_id !== 5'b01_001 || b_m.ar_qos !== 4'd5) begin n_bad++; $display("FAIL qos_fwd: got id=%b qos=%0d want 01001/5", b_m.ar_id, b_m.ar_qos); end
    b_s.ar_qos[0] = 4'd7; b_s.ar_qos[2] = 4'd7; b_s.ar_id[0] = 3'd0; b_s.ar_id[2] = 3'd2;
    b_s.ar_valid = 4'b0101;
    #1;
    n_cmp++; if (b_s.ar_ready !== 4'b0100) begin n_bad++; $display("FAIL qos_tie_rr: got %b want 0100", b_s.ar_ready); end
    step();
    b_s.ar_valid = 4'b0001;
    #1;
    n_cmp++; if (b_s.ar_ready !== 4'b0001 || b_m.ar_id !== 5'b10_010) begin n_bad++; $display("FAIL qos_tie_next: got ready=%b id=%b want 0001/10010", b_s.ar_ready, b_m.ar_id); end
    step();
    b_s.ar_valid = 4'b0000;
    #1;
    n_cmp++; if (b_m.ar_id !== 5'b00_000 || b_m.ar_valid !== 1'b1) begin n_bad++; $display("FAIL qos_tie_fwd: got v=%b id=%b want 1/00000", b_m.ar_valid, b_m.ar_id); end
    do_reset();
  endtask

  task automatic test_err();
    c_m.r_valid = 1'b1; c_m.r_id = 5'b11_010; c_m.r_last = 1'b1; c_s.r_ready = 3'b000;
    #1;
    n_cmp++; if (c_m.r_ready !== 1'b1 || c_s.r_valid !== 3'b000) begin n_bad++; $display("FAIL err_drop: got rr=%b v=%b want 1/000", c_m.r_ready, c_s.r_valid); end
    n_cmp++; if (err_c !== 1'b0) begin n_bad++; $display("FAIL err_early: got %b want 0", err_c); end
    step();
    c_m.r_valid = 1'b0;
    #1;
    n_cmp++; if (err_c !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err_c); end
    c_m.r_valid = 1'b1; c_m.r_id = 5'b01_000; c_m.r_last = 1'b0;
    #1;
    n_cmp++; if (c_m.r_ready !== 1'b0 || c_s.r_valid !== 3'b010) begin n_bad++; $display("FAIL err_inrange_bp: got rr=%b v=%b want 0/010", c_m.r_ready, c_s.r_valid); end
    c_s.r_ready = 3'b010;
    #1;
    n_cmp++; if (c_m.r_ready !== 1'b1) begin n_bad++; $display("FAIL err_inrange_rdy: got %b want 1", c_m.r_ready); end
    step();
    c_m.r_valid = 1'b0; c_s.r_ready = 3'b000;
    step(); step(); step();
    n_cmp++; if (err_c !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err_c); end
    rst = 1'b1;
    #1;
    n_cmp++; if (err_c !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", err_c); end
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_rr();
    test_limit();
    test_stall();
    test_same_cycle();
    test_reset_mid();
    test_qos();
    test_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
